// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// the halt opcode, the NOP word and the fetch-stage record.
package instruction_fetch_unit_pkg;

  // 2-bit FSM state encoding
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // Opcode (instr[31:26]) that stops fetching
  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

  // Word held in the fetch register after reset
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Saturation ceiling of the captured-instruction counter
  localparam logic [31:0] FETCH_COUNT_MAX = 32'hFFFF_FFFF;

  // Contents of the fetch stage handed to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  // Sequential next PC; wraps modulo 2^32
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Saturating increment of the fetch counter
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == FETCH_COUNT_MAX) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter flop: load has priority over increment, otherwise hold.
// Reset loads RESET_PC.
module pc_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_value_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next-PC selection: redirect load, sequential increment or hold
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_value_i;
    end else if (inc_i) begin
      pc_d = next_seq_pc(pc_q);
    end
  end

  // PC state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory
// address, registers the returned word for decode and handles stall,
// redirect, halt-opcode detection and address faults.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256,
  parameter logic [5:0]  HALT_OP    = HALT_OP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] readAddress,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branchValid,
  input  logic [31:0] branchTarget,
  output logic        fetchValid,
  output logic [31:0] fetchPC,
  output logic [31:0] fetchInstruction,
  output logic [31:0] pcPlus4,
  output logic        halted,
  output logic        addrFault,
  output logic [31:0] fetchCount
);

  // Highest legal word address; compared against the full 32-bit PC
  localparam logic [31:0] PC_MAX = IMEM_BYTES - 32'd4;

  localparam fetch_entry_t FETCH_RESET = '{pc: 32'h0, instr: NOP_WORD, pc_plus4: 32'h0};

  logic [1:0]   state_q, state_d;
  fetch_entry_t fetch_q, fetch_d;
  logic         fv_q, fv_d;
  logic [31:0]  cnt_q, cnt_d;

  logic         pc_load;
  logic         pc_inc;
  logic [31:0]  pc;
  logic         pc_legal;
  logic         is_halt_word;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk         (clk),
    .reset       (reset),
    .load_i      (pc_load),
    .load_value_i(branchTarget),
    .inc_i       (pc_inc),
    .pc_o        (pc)
  );

  assign readAddress  = pc;
  assign pc_legal     = (pc[1:0] == 2'b00) && (pc <= PC_MAX);
  assign is_halt_word = (instruction[31:26] == HALT_OP);

  // Fetch FSM: in RUN the order is redirect, fault check, stall, capture
  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    fv_d    = fv_q;
    cnt_d   = cnt_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (branchValid) begin
          // Redirect wins over stall and leaves one bubble behind it
          pc_load = 1'b1;
          fv_d    = 1'b0;
        end else if (!pc_legal) begin
          state_d = ST_FAULT;
          fv_d    = 1'b0;
        end else if (!stall) begin
          fetch_d = '{pc: pc, instr: instruction, pc_plus4: next_seq_pc(pc)};
          fv_d    = 1'b1;
          cnt_d   = sat_inc(cnt_q);
          if (is_halt_word) begin
            // PC stays on the halt word
            state_d = ST_HALT;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (branchValid) begin
          state_d = ST_RUN;
          pc_load = 1'b1;
          fv_d    = 1'b0;
        end else if (!stall) begin
          // Halt word has been consumed by decode
          fv_d = 1'b0;
        end
      end
      ST_FAULT: begin
        fv_d = 1'b0;
      end
      default: begin
        // Unused encoding: park in the terminal fault state
        state_d = ST_FAULT;
        fv_d    = 1'b0;
      end
    endcase
  end

  // FSM, fetch register and counter state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      fetch_q <= FETCH_RESET;
      fv_q    <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      fv_q    <= fv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetchValid       = fv_q;
  assign fetchPC          = fetch_q.pc;
  assign fetchInstruction = fetch_q.instr;
  assign pcPlus4          = fetch_q.pc_plus4;
  assign halted           = (state_q == ST_HALT);
  assign addrFault        = (state_q == ST_FAULT);
  assign fetchCount       = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit with a byte-array instruction memory
// and a cycle-level reference model of the fetch rules.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam int          MEM_SIZE = 256;

  localparam int M_RUN   = 0;
  localparam int M_HALT  = 1;
  localparam int M_FAULT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchValid;
  logic [31:0] branchTarget;
  logic [31:0] readAddress;
  logic [31:0] instruction;
  logic        fetchValid;
  logic [31:0] fetchPC;
  logic [31:0] fetchInstruction;
  logic [31:0] pcPlus4;
  logic        halted;
  logic        addrFault;
  logic [31:0] fetchCount;

  logic [7:0] mem [0:MEM_SIZE-1];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_state;
  logic [31:0] m_pc, m_fpc, m_finstr, m_p4, m_cnt;
  logic        m_fv;

  instruction_fetch_unit #(
    .RESET_PC  (RST_PC),
    .IMEM_BYTES(MEM_SIZE),
    .HALT_OP   (6'b111111)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .readAddress     (readAddress),
    .instruction     (instruction),
    .stall           (stall),
    .branchValid     (branchValid),
    .branchTarget    (branchTarget),
    .fetchValid      (fetchValid),
    .fetchPC         (fetchPC),
    .fetchInstruction(fetchInstruction),
    .pcPlus4         (pcPlus4),
    .halted          (halted),
    .addrFault       (addrFault),
    .fetchCount      (fetchCount)
  );

  always #5 clk = ~clk;

  // Combinational big-endian memory read; reads past the end return zero
  always_comb begin
    instruction = 32'h0;
    if (readAddress <= 32'd252) begin
      instruction = {mem[readAddress[7:0]], mem[readAddress[7:0] + 8'd1],
                     mem[readAddress[7:0] + 8'd2], mem[readAddress[7:0] + 8'd3]};
    end
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (a > 32'd252) return 32'h0;
    return {mem[a[7:0]], mem[a[7:0] + 8'd1], mem[a[7:0] + 8'd2], mem[a[7:0] + 8'd3]};
  endfunction

  task automatic put_word(input int addr, input logic [31:0] w);
    mem[addr]     = w[31:24];
    mem[addr + 1] = w[23:16];
    mem[addr + 2] = w[15:8];
    mem[addr + 3] = w[7:0];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge with the given inputs
  task automatic model_step(input logic r, input logic s, input logic bv, input logic [31:0] bt);
    logic [31:0] w;
    if (r) begin
      m_state = M_RUN; m_pc = RST_PC; m_fv = 1'b0;
      m_fpc = 32'h0; m_finstr = 32'h0; m_p4 = 32'h0; m_cnt = 32'h0;
    end else if (m_state == M_RUN) begin
      if (bv) begin
        m_pc = bt; m_fv = 1'b0;
      end else if ((m_pc % 4) != 0 || m_pc > MEM_SIZE - 4) begin
        m_state = M_FAULT; m_fv = 1'b0;
      end else if (!s) begin
        w = ref_word(m_pc);
        m_finstr = w; m_fpc = m_pc; m_p4 = m_pc + 32'd4; m_fv = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (w[31:26] == 6'b111111) m_state = M_HALT;
        else m_pc = m_pc + 32'd4;
      end
    end else if (m_state == M_HALT) begin
      if (bv) begin
        m_state = M_RUN; m_pc = bt; m_fv = 1'b0;
      end else if (!s) begin
        m_fv = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("readAddress",      readAddress,              m_pc);
    check("fetchValid",       {31'h0, fetchValid},      {31'h0, m_fv});
    check("fetchPC",          fetchPC,                  m_fpc);
    check("fetchInstruction", fetchInstruction,         m_finstr);
    check("pcPlus4",          pcPlus4,                  m_p4);
    check("halted",           {31'h0, halted},          {31'h0, (m_state == M_HALT)});
    check("addrFault",        {31'h0, addrFault},       {31'h0, (m_state == M_FAULT)});
    check("fetchCount",       fetchCount,               m_cnt);
  endtask

  // Drive one cycle's inputs, clock it, then compare against the model
  task automatic cycle(input logic r, input logic s, input logic bv, input logic [31:0] bt);
    reset = r; stall = s; branchValid = bv; branchTarget = bt;
    model_step(r, s, bv, bt);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] w;
    logic        r, s, bv;
    logic [31:0] bt;

    reset = 1'b1; stall = 1'b0; branchValid = 1'b0; branchTarget = 32'h0;
    m_state = M_RUN; m_pc = RST_PC; m_fv = 1'b0;
    m_fpc = 32'h0; m_finstr = 32'h0; m_p4 = 32'h0; m_cnt = 32'h0;

    for (int i = 0; i < MEM_SIZE / 4; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b111111) w[31:26] = 6'b000000;
      put_word(i * 4, w);
    end
    put_word(32'h0C, 32'hFC00_0000);
    put_word(32'h80, 32'hFC12_3456);

    // Reset
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    check("reset_fetchCount", fetchCount, 32'h0);
    check("reset_readAddress", readAddress, RST_PC);

    // Plain fetches from 0 and 4
    cycle(0, 0, 0, 32'h0);
    check("first_fetchPC", fetchPC, 32'h0);
    cycle(0, 0, 0, 32'h0);

    // Stall two cycles at PC=8, then release
    cycle(0, 1, 0, 32'h0);
    cycle(0, 1, 0, 32'h0);
    check("stall_readAddress", readAddress, 32'h8);
    cycle(0, 0, 0, 32'h0);
    check("after_stall_fetchPC", fetchPC, 32'h8);
    check("three_fetches", fetchCount, 32'd3);

    // Redirect beats stall: bubble then 0x40
    cycle(0, 1, 1, 32'h40);
    cycle(0, 0, 0, 32'h0);
    check("redirect_fetchPC", fetchPC, 32'h40);

    // Halt word at 0x0C; stall holds its valid, then it drops
    cycle(0, 0, 1, 32'h0C);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 1, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    // Branch out of HALT and resume
    cycle(0, 0, 1, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);

    // Misaligned target faults; branches then ignored
    cycle(0, 0, 1, 32'h42);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 1, 32'h0);
    cycle(0, 0, 0, 32'h0);
    check("fault_sticky", {31'h0, addrFault}, 32'h1);

    // Reset while stalled and branching
    cycle(0, 1, 0, 32'h0);
    cycle(1, 1, 1, 32'h40);
    check("midreset_readAddress", readAddress, RST_PC);

    // Run off the end of memory
    cycle(0, 0, 1, 32'hF8);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      if (m_state == M_FAULT && $urandom_range(0, 7) == 0) r = 1'b1;
      s  = ($urandom_range(0, 99) < 25);
      bv = ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 9))
        0:       bt = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        1:       bt = 32'h100 + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        2:       bt = 32'h0C;
        default: bt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      endcase
      cycle(r, s, bv, bt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
